// File: rtl/avl_mm_master_arbiter.sv
// Two-requester Avalon-MM arbiter onto one master port, round-robin on ties.
// Optional waitrequest timeout enabled by defining AVL_ARB_TIMEOUT_EN.
module avl_mm_master_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] r0_address,
   input  logic [DATA_W-1:0] r0_writedata,
   input  logic              r0_read,
   input  logic              r0_write,
   output logic [DATA_W-1:0] r0_readdata,
   output logic              r0_waitrequest,
   input  logic [ADDR_W-1:0] r1_address,
   input  logic [DATA_W-1:0] r1_writedata,
   input  logic              r1_read,
   input  logic              r1_write,
   output logic [DATA_W-1:0] r1_readdata,
   output logic              r1_waitrequest,
   output logic [ADDR_W-1:0] avm_address,
   output logic [DATA_W-1:0] avm_writedata,
   output logic              avm_read,
   output logic              avm_write,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest,
   output logic              arb_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_grant;
   logic              r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_avm_read;
   logic              r_avm_write;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              r_err;
   logic              w_req0;
   logic              w_req1;
   logic              w_pick;
   logic              w_sel_read;
   logic              w_sel_write;
   logic              w_timeout;

   assign w_req0 = r0_read | r0_write;
   assign w_req1 = r1_read | r1_write;
   // On a tie the requester not granted last wins; otherwise the only one asking.
   assign w_pick      = (w_req0 && w_req1) ? ~r_last : w_req1;
   assign w_sel_read  = w_pick ? r1_read  : r0_read;
   assign w_sel_write = w_pick ? r1_write : r0_write;

`ifdef AVL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_cnt;

   assign w_timeout = (r_state == S_BUS) && avm_waitrequest &&
                      (r_cnt == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state != S_BUS) begin
         r_cnt <= '0;
      end else if (avm_waitrequest && !w_timeout) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req0 || w_req1) w_state_next = S_BUS;
         S_BUS:   if (!avm_waitrequest || w_timeout) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_grant     <= 1'b0;
         r_last      <= 1'b1;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_avm_read  <= 1'b0;
         r_avm_write <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req0 || w_req1) begin
                  r_grant     <= w_pick;
                  r_addr      <= w_pick ? r1_address : r0_address;
                  r_wdata     <= w_pick ? r1_writedata : r0_writedata;
                  r_avm_read  <= w_sel_read;
                  r_avm_write <= w_sel_write & ~w_sel_read;
               end
            end
            S_BUS: begin
               if (!avm_waitrequest) begin
                  r_avm_read  <= 1'b0;
                  r_avm_write <= 1'b0;
                  if (r_avm_read) begin
                     if (r_grant) r_rdata1 <= avm_readdata;
                     else         r_rdata0 <= avm_readdata;
                  end
               end else if (w_timeout) begin
                  // Abandon the stalled command; reads return a marker word.
                  r_avm_read  <= 1'b0;
                  r_avm_write <= 1'b0;
                  r_err       <= 1'b1;
                  if (r_avm_read) begin
                     if (r_grant) r_rdata1 <= DATA_W'(32'hDEADBEEF);
                     else         r_rdata0 <= DATA_W'(32'hDEADBEEF);
                  end
               end
            end
            S_DONE: r_last <= r_grant;
            default: ;
         endcase
      end
   end

   assign avm_address    = r_addr;
   assign avm_writedata  = r_wdata;
   assign avm_read       = r_avm_read;
   assign avm_write      = r_avm_write;
   assign r0_readdata    = r_rdata0;
   assign r1_readdata    = r_rdata1;
   assign r0_waitrequest = ~((r_state == S_DONE) && !r_grant);
   assign r1_waitrequest = ~((r_state == S_DONE) &&  r_grant);
   assign arb_err        = r_err;

endmodule

// File: tb/tb_avl_mm_master_arbiter.sv
// Directed bench for avl_mm_master_arbiter; timeout scenario runs only when
// AVL_ARB_TIMEOUT_EN is defined.
module tb_avl_mm_master_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] r0_address, r0_writedata, r0_readdata;
   logic        r0_read, r0_write, r0_waitrequest;
   logic [31:0] r1_address, r1_writedata, r1_readdata;
   logic        r1_read, r1_write, r1_waitrequest;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest, arb_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   avl_mm_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .reset(reset),
      .r0_address(r0_address), .r0_writedata(r0_writedata), .r0_read(r0_read),
      .r0_write(r0_write), .r0_readdata(r0_readdata), .r0_waitrequest(r0_waitrequest),
      .r1_address(r1_address), .r1_writedata(r1_writedata), .r1_read(r1_read),
      .r1_write(r1_write), .r1_readdata(r1_readdata), .r1_waitrequest(r1_waitrequest),
      .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_read(avm_read),
      .avm_write(avm_write), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest), .arb_err(arb_err)
   );

   task automatic clear_inputs();
      r0_address = 0; r0_writedata = 0; r0_read = 0; r0_write = 0;
      r1_address = 0; r1_writedata = 0; r1_read = 0; r1_write = 0;
      avm_readdata = 0; avm_waitrequest = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      r0_read = 1'b1;
      r0_address = 32'hFFFF_0000;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({avm_read, avm_write, arb_err} !== 3'b000) begin
         errors++; $display("FAIL reset_cmd: got %b required 000", {avm_read, avm_write, arb_err});
      end
      checks++;
      if (avm_address !== 32'h0 || avm_writedata !== 32'h0) begin
         errors++; $display("FAIL reset_addr_data: got %h/%h required 0/0", avm_address, avm_writedata);
      end
      checks++;
      if (r0_readdata !== 32'h0 || r1_readdata !== 32'h0) begin
         errors++; $display("FAIL reset_readdata: got %h/%h required 0/0", r0_readdata, r1_readdata);
      end
      checks++;
      if ({r0_waitrequest, r1_waitrequest} !== 2'b11) begin
         errors++; $display("FAIL reset_wait: got %b required 11", {r0_waitrequest, r1_waitrequest});
      end
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      $display("test_reset done: errors=%0d", errors);
   endtask

   task automatic test_read();
      int low_at = -1, low_n = 0, rd_n = 0, addr_bad = 0, other_low = 0;
      logic [31:0] rdata_at_low = 32'h0;
      r0_address = 32'h10; r0_read = 1'b1;
      avm_readdata = 32'hA5A5A5A5; avm_waitrequest = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (avm_read === 1'b1) begin
            rd_n++;
            if (avm_address !== 32'h10) addr_bad++;
         end
         if (r0_waitrequest === 1'b0) begin
            low_n++;
            if (low_at < 0) low_at = c;
            rdata_at_low = r0_readdata;
            r0_read = 1'b0;
         end
         if (r1_waitrequest !== 1'b1) other_low++;
      end
      checks++;
      if (low_at != 2) begin errors++; $display("FAIL read_latency: got %0d required 2", low_at); end
      checks++;
      if (low_n != 1) begin errors++; $display("FAIL read_wait_pulses: got %0d required 1", low_n); end
      checks++;
      if (rd_n != 1) begin errors++; $display("FAIL read_avm_cycles: got %0d required 1", rd_n); end
      checks++;
      if (addr_bad != 0) begin errors++; $display("FAIL read_addr: got %0d bad cycles required 0", addr_bad); end
      checks++;
      if (rdata_at_low !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL read_data: got %h required a5a5a5a5", rdata_at_low);
      end
      checks++;
      if (other_low != 0) begin errors++; $display("FAIL read_other_wait: got %0d required 0", other_low); end
      $display("test_read done: errors=%0d", errors);
   endtask

   task automatic test_rw_both();
      int rd_n = 0, wr_n = 0, low_n = 0;
      r1_address = 32'h20; r1_writedata = 32'h77; r1_read = 1'b1; r1_write = 1'b1;
      avm_readdata = 32'h11111111; avm_waitrequest = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (avm_read === 1'b1) rd_n++;
         if (avm_write === 1'b1) wr_n++;
         if (r1_waitrequest === 1'b0) begin
            low_n++; r1_read = 1'b0; r1_write = 1'b0;
         end
      end
      checks++;
      if (rd_n != 1 || wr_n != 0) begin
         errors++; $display("FAIL rw_both_cmd: got rd=%0d wr=%0d required rd=1 wr=0", rd_n, wr_n);
      end
      checks++;
      if (low_n != 1) begin errors++; $display("FAIL rw_both_wait: got %0d required 1", low_n); end
      checks++;
      if (r1_readdata !== 32'h11111111) begin
         errors++; $display("FAIL rw_both_data: got %h required 11111111", r1_readdata);
      end
      checks++;
      if (r0_readdata !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL r0_readdata_hold: got %h required a5a5a5a5", r0_readdata);
      end
      $display("test_rw_both done: errors=%0d", errors);
   endtask

   task automatic test_round_robin();
      logic [31:0] grants [8];
      int n = 0, both_low = 0, stray = 0, overlap = 0, wd_bad = 0;
      bit pending = 0;
      apply_reset();
      r0_address = 32'h100; r0_writedata = 32'hAAAA; r0_write = 1'b1;
      r1_address = 32'h200; r1_writedata = 32'hBBBB; r1_write = 1'b1;
      avm_waitrequest = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (avm_write === 1'b1) begin
            if (pending) overlap++;
            pending = 1;
            if (n < 8) grants[n] = avm_address;
            n++;
            if (avm_writedata !== ((avm_address == 32'h100) ? 32'hAAAA : 32'hBBBB)) wd_bad++;
         end
         if (r0_waitrequest === 1'b0 || r1_waitrequest === 1'b0) pending = 0;
         if (r0_waitrequest === 1'b0 && r1_waitrequest === 1'b0) both_low++;
         if (avm_read === 1'b1) stray++;
      end
      r0_write = 1'b0; r1_write = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (n < 4) begin
         errors++; $display("FAIL rr_count: got %0d grants required >=4", n);
      end else begin
         checks++;
         if (grants[0] !== 32'h100 || grants[1] !== 32'h200 ||
             grants[2] !== 32'h100 || grants[3] !== 32'h200) begin
            errors++;
            $display("FAIL rr_order: got %h %h %h %h required 100 200 100 200",
                     grants[0], grants[1], grants[2], grants[3]);
         end
      end
      checks++;
      if (overlap != 0 || both_low != 0 || stray != 0) begin
         errors++; $display("FAIL rr_single_outstanding: got overlap=%0d both_low=%0d stray=%0d required 0",
                            overlap, both_low, stray);
      end
      checks++;
      if (wd_bad != 0) begin errors++; $display("FAIL rr_writedata: got %0d bad required 0", wd_bad); end
      $display("test_round_robin done: errors=%0d", errors);
   endtask

   task automatic test_wait_hold();
      int hold_bad = 0, early = 0;
      r1_address = 32'h4; r1_writedata = 32'h1234; r1_write = 1'b1;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 5; c++) begin
         if (avm_write !== 1'b1 || avm_address !== 32'h4 || avm_writedata !== 32'h1234) hold_bad++;
         if (r1_waitrequest !== 1'b1) early++;
         if (c == 5) avm_waitrequest = 1'b0;
         else @(negedge clk);
      end
      checks++;
      if (hold_bad != 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles required 0", hold_bad); end
      checks++;
      if (early != 0) begin errors++; $display("FAIL hold_early_wait: got %0d required 0", early); end
      @(negedge clk);
      checks++;
      if (r1_waitrequest !== 1'b0 || avm_write !== 1'b0 || r0_waitrequest !== 1'b1) begin
         errors++; $display("FAIL hold_release: got r1w=%b avw=%b r0w=%b required 0 0 1",
                            r1_waitrequest, avm_write, r0_waitrequest);
      end
      r1_write = 1'b0;
      @(negedge clk);
      checks++;
      if (r1_waitrequest !== 1'b1) begin
         errors++; $display("FAIL hold_pulse_len: got %b required 1", r1_waitrequest);
      end
      $display("test_wait_hold done: errors=%0d", errors);
   endtask

   task automatic test_drop_and_late();
      int wr30 = 0, rd_bad = 0, r0_low = 0, r1_low = 0, r0_at = -1, r1_at = -1;
      r0_address = 32'h30; r0_writedata = 32'h9; r0_write = 1'b1;
      avm_waitrequest = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (avm_write === 1'b1 && avm_address === 32'h30) wr30++;
         if (avm_read === 1'b1 && avm_address !== 32'h40) rd_bad++;
         if (r0_waitrequest === 1'b0) begin r0_low++; r0_at = c; end
         if (r1_waitrequest === 1'b0) begin r1_low++; r1_at = c; r1_read = 1'b0; end
         if (c == 1) begin
            r0_write = 1'b0;
            r1_address = 32'h40; r1_read = 1'b1; avm_readdata = 32'h22222222;
         end
         if (c == 3) avm_waitrequest = 1'b0;
      end
      checks++;
      if (wr30 != 3) begin errors++; $display("FAIL drop_write_kept: got %0d cycles required 3", wr30); end
      checks++;
      if (r0_low != 1 || r1_low != 1 || r0_at != 4 || r1_at != 7) begin
         errors++; $display("FAIL drop_completions: got r0=%0d@%0d r1=%0d@%0d required 1@4 1@7",
                            r0_low, r0_at, r1_low, r1_at);
      end
      checks++;
      if (rd_bad != 0 || r1_readdata !== 32'h22222222) begin
         errors++; $display("FAIL late_read: got bad=%0d data=%h required 0 22222222", rd_bad, r1_readdata);
      end
      $display("test_drop_and_late done: errors=%0d", errors);
   endtask

   task automatic test_reset_mid_bus();
      int spurious = 0;
      r0_address = 32'h50; r0_writedata = 32'h5; r0_write = 1'b1;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      checks++;
      if (avm_write !== 1'b1) begin errors++; $display("FAIL midbus_enter: got %b required 1", avm_write); end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (avm_write !== 1'b0 || avm_read !== 1'b0 || avm_address !== 32'h0 ||
          r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin
         errors++; $display("FAIL midbus_abort: got w=%b r=%b a=%h r0w=%b r1w=%b required 0 0 0 1 1",
                            avm_write, avm_read, avm_address, r0_waitrequest, r1_waitrequest);
      end
      reset = 1'b1; r0_write = 1'b0; avm_waitrequest = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1 || avm_write !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin errors++; $display("FAIL midbus_no_completion: got %0d required 0", spurious); end
      $display("test_reset_mid_bus done: errors=%0d", errors);
   endtask

`ifdef AVL_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int err_n = 0, low_n = 0;
      r0_address = 32'h60; r0_read = 1'b1;
      avm_readdata = 32'h0; avm_waitrequest = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (arb_err === 1'b1) err_n++;
         if (r0_waitrequest === 1'b0) begin low_n++; r0_read = 1'b0; end
      end
      checks++;
      if (err_n != 1) begin errors++; $display("FAIL timeout_err: got %0d pulses required 1", err_n); end
      checks++;
      if (low_n != 1 || r0_readdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL timeout_data: got low=%0d data=%h required 1 deadbeef", low_n, r0_readdata);
      end
      checks++;
      if (avm_read !== 1'b0 || r0_waitrequest !== 1'b1) begin
         errors++; $display("FAIL timeout_idle: got r=%b w=%b required 0 1", avm_read, r0_waitrequest);
      end
      avm_waitrequest = 1'b0;
      $display("test_timeout done: errors=%0d", errors);
   endtask
`endif

   initial begin
      clear_inputs();
      reset = 1'b0;
      test_reset();
      test_read();
      test_rw_both();
      test_round_robin();
      test_wait_hold();
      test_drop_and_late();
      test_reset_mid_bus();
`ifdef AVL_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
